// File: rtl/fxp_out_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : fxp_out_buffer_if
// Brief    : Sample input, status and ready/valid output bundle for fxp_out_buffer.
// Revision : 1.0
// ============================================================================
interface fxp_out_buffer_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 14,
  parameter int DEPTH = 8
);
  logic [IN_W-1:0]          in;
  logic                     valid;
  logic                     clr;
  logic [OUT_W-1:0]         out;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     overflow;
  logic                     sat;

  modport master (
    output in, valid, clr, out_ready,
    input  out, out_valid, count, full, overflow, sat
  );

  modport slave (
    input  in, valid, clr, out_ready,
    output out, out_valid, count, full, overflow, sat
  );
endinterface
`default_nettype wire

// File: rtl/fxp_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fxp_out_buffer
// Brief    : Drops LSBs of the filter result (rounding when OUTPUT_ROUND_EN is
//            defined, truncation otherwise), saturates, and queues the result
//            in a first-word-fall-through FIFO with a ready/valid output.
// Revision : 1.0
// ============================================================================
module fxp_out_buffer #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 14,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  fxp_out_buffer_if.slave    bus
);
  localparam int c_D  = IN_W - OUT_W;
  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

  logic signed [IN_W:0]   w_ext;
  logic signed [IN_W:0]   w_q;
  logic [IN_W-OUT_W+1:0]  w_hi;
  logic                   w_clip;
  logic [OUT_W-1:0]       w_red;
  logic                   w_outValid;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_wrEn;

  logic                   r_qv;
  logic [OUT_W-1:0]       r_qData;
  logic [OUT_W-1:0]       r_mem [DEPTH];
  logic [c_AW-1:0]        r_wrPtr;
  logic [c_AW-1:0]        r_rdPtr;
  logic [c_AW:0]          r_count;
  logic                   r_sat;
  logic                   r_overflow;

  assign w_ext = {bus.in[IN_W-1], bus.in};

`ifdef OUTPUT_ROUND_EN
  localparam logic signed [IN_W:0] c_HALF = (IN_W + 1)'(1) << (c_D - 1);
  assign w_q = (w_ext + c_HALF) >>> c_D;
`else
  assign w_q = w_ext >>> c_D;
`endif

  // In range only when every bit from the output sign upward agrees.
  assign w_hi   = w_q[IN_W:OUT_W-1];
  assign w_clip = !((&w_hi) || !(|w_hi));
  assign w_red  = !w_clip      ? w_q[OUT_W-1:0] :
                  w_q[IN_W]    ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 {1'b0, {(OUT_W-1){1'b1}}};

  assign w_outValid = (r_count != '0);
  assign w_full     = (r_count == c_DEPTH);
  assign w_pop      = w_outValid && bus.out_ready;
  // A full FIFO still takes the sample when the head leaves in the same cycle.
  assign w_wrEn     = r_qv && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qv       <= 1'b0;
      r_qData    <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_sat      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_qv <= bus.valid;
      if (bus.valid) begin
        r_qData <= w_red;
      end
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_wrEn, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.valid && w_clip) begin
        r_sat <= 1'b1;
      end else if (bus.clr) begin
        r_sat <= 1'b0;
      end
      if (r_qv && !w_wrEn) begin
        r_overflow <= 1'b1;
      end else if (bus.clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= r_qData;
    end
  end

  assign bus.out       = w_outValid ? r_mem[r_rdPtr] : '0;
  assign bus.out_valid = w_outValid;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.sat       = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_fxp_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fxp_out_buffer
// Brief    : Directed self-checking bench for fxp_out_buffer (either build).
// Revision : 1.0
// ============================================================================
module tb_fxp_out_buffer;
  localparam int IN_W  = 24;
  localparam int OUT_W = 14;
  localparam int DEPTH = 8;

`ifdef OUTPUT_ROUND_EN
  localparam logic [31:0] c_EXP_1536 = 32'd2;
  localparam logic [31:0] c_EXP_M512 = 32'd0;
  localparam logic [31:0] c_EXP_SAT  = 32'd1;
`else
  localparam logic [31:0] c_EXP_1536 = 32'd1;
  localparam logic [31:0] c_EXP_M512 = 32'h3FFF;
  localparam logic [31:0] c_EXP_SAT  = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nErr = 0;
  int   nChk = 0;

  fxp_out_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  fxp_out_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill10();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in    = 24'(1024 * i);
      bus.valid = 1'b1;
      tick();
    end
    bus.valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] expOrder [8];
    bus.in        = '0;
    bus.valid     = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_full",      32'(bus.full),      32'd0);
    check("rst_out",       32'(bus.out),       32'd0);
    check("rst_flags",     32'({bus.sat, bus.overflow}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Rounding and two-cycle latency
    bus.in = 24'h000600; bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    check("lat_k_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_k1_out_valid", 32'(bus.out_valid), 32'd1);
    check("round_1536", 32'(bus.out), c_EXP_1536);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pop_count", 32'(bus.count), 32'd0);
    check("empty_out", 32'(bus.out), 32'd0);

    // Negative values
    bus.in = 24'hFFFE00; bus.valid = 1'b1;
    tick();
    bus.in = 24'h800000;
    tick();
    bus.valid = 1'b0;
    check("neg_m512", 32'(bus.out), c_EXP_M512);
    tick();
    check("neg_count", 32'(bus.count), 32'd2);
    bus.out_ready = 1'b1;
    tick();
    check("neg_min", 32'(bus.out), 32'h2000);
    check("neg_min_sat", 32'(bus.sat), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    check("neg_drained", 32'(bus.count), 32'd0);

    // Saturation at the positive extreme
    bus.in = 24'h7FFFFF; bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    check("sat_flag", 32'(bus.sat), c_EXP_SAT);
    tick();
    check("sat_out", 32'(bus.out), 32'h1FFF);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("sat_clr", 32'(bus.sat), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Fill past capacity
    fill10();
    check("fill_count",    32'(bus.count),    32'd8);
    check("fill_full",     32'(bus.full),     32'd1);
    check("fill_overflow", 32'(bus.overflow), 32'd1);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full FIFO: write coincides with a pop
    bus.in = 24'(1024 * 20); bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    check("pre_pop_count", 32'(bus.count), 32'd8);
    bus.out_ready = 1'b1;
    check("full_head", 32'(bus.out), 32'd0);
    tick();
    check("fullpop_count",    32'(bus.count),    32'd8);
    check("fullpop_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 7; i++) expOrder[i] = 32'(i + 1);
    expOrder[7] = 32'd20;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(bus.out), expOrder[i]);
      tick();
    end
    bus.out_ready = 1'b0;
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    check("drain_out",   32'(bus.out),       32'd0);

    // Reset mid-stream with five entries queued and overflow set
    fill10();
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    bus.out_ready = 1'b0;
    check("mid_count",    32'(bus.count),    32'd5);
    check("mid_overflow", 32'(bus.overflow), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_count",     32'(bus.count),     32'd0);
    check("arst_out",       32'(bus.out),       32'd0);
    check("arst_flags",     32'({bus.sat, bus.overflow, bus.full}), 32'd0);
    tick();
    rst = 1'b0;
    bus.in = 24'(1024 * 5); bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
    check("post_rst_k", 32'(bus.out_valid), 32'd0);
    tick();
    check("post_rst_k1", 32'(bus.out_valid), 32'd1);
    check("post_rst_out", 32'(bus.out), 32'd5);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
`default_nettype wire
